ps2_key_tracker: RTL and testbench

- Consumes the byte stream of the PS/2 receiver FIFO (ready/nextdata_n handshake) and decodes make, break (F0) and extended (E0) codes.
- Tracks the currently held key and counts distinct key presses; typematic repeats are not counted.
- Drives a parametrised bank of active-low seven-segment digits: scan code, ASCII, press count.
- Sits between ps2_keyboard and the board seg outputs in SimTop.

---
 rtl/ps2_kbd_pkg.sv | 42 ++++
 rtl/ps2_key_tracker_scan2ascii.sv | 40 ++++
 rtl/ps2_key_tracker.sv | 153 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, pop-FSM states and seven-segment helpers for the PS/2 key tracker.
package ps2_kbd_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] LSHIFT   = 8'h12;
  localparam logic [7:0] RSHIFT   = 8'h59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } pop_state_e;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_scan2ascii.sv
// Set-2 scan code to ASCII table: letters, digits, space and enter; extended codes map to 0x00.
module scan2ascii
  import ps2_kbd_pkg::*;
(
  input  logic [8:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;

  always_comb begin
    case (code[7:0])
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
      8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
      8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
      8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      default: base = 8'h00;
    endcase

    ascii = base;
    if (code[8]) begin
      ascii = 8'h00;
    end else if (shift && base >= 8'h61 && base <= 8'h7A) begin
      ascii = base - 8'h20;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: pops the receiver FIFO, decodes make/break/extended codes and drives seven-segment digits.
// Optional shift tracking (uppercase letters, shift keys not counted) is enabled with `define KBD_SHIFT_EN.
module ps2_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter  int CNT_W      = 8,
  localparam int NUM_DIGITS = 4 + CNT_W / 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_ready,
  input  logic                    in_overflow,
  output logic                    nextdata_n,
  output logic                    key_valid,
  output logic                    key_held,
  output logic [8:0]              key_code,
  output logic [7:0]              key_ascii,
  output logic [CNT_W-1:0]        press_count,
  output logic                    overflow_seen,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  pop_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [8:0]       key_code_q, key_code_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             ovf_q, ovf_d;
  logic             shift_down_q, shift_down_d;
  logic [8:0]       code_c;
  logic             shift_hit;

  assign code_c = {ext_q, byte_q};

`ifdef KBD_SHIFT_EN
  assign shift_hit = !ext_q && (byte_q == LSHIFT || byte_q == RSHIFT);
`else
  assign shift_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    byte_vld_d   = 1'b0;
    nextdata_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          byte_d       = in_data;
          byte_vld_d   = 1'b1;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP:     state_d = SETTLE;
      // Gives the FIFO a cycle to update in_ready after the pop.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    brk_d         = brk_q;
    ext_d         = ext_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    key_code_d    = key_code_q;
    press_count_d = press_count_q;
    shift_down_d  = shift_down_q;
    ovf_d         = ovf_q | in_overflow;
    if (byte_vld_q) begin
      if (byte_q == BRK_CODE) begin
        brk_d = 1'b1;
      end else if (byte_q == EXT_CODE) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (shift_hit) begin
          shift_down_d = !brk_q;
        end else if (brk_q) begin
          if (key_held_q && code_c == key_code_q) key_held_d = 1'b0;
        end else if (!(key_held_q && code_c == key_code_q)) begin
          key_code_d    = code_c;
          key_held_d    = 1'b1;
          press_count_d = press_count_q + 1'b1;
          key_valid_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    byte_q <= byte_d;
    if (reset) begin
      state_q       <= IDLE;
      byte_vld_q    <= 1'b0;
      nextdata_n_q  <= 1'b1;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_code_q    <= '0;
      press_count_q <= '0;
      ovf_q         <= 1'b0;
      shift_down_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_vld_q    <= byte_vld_d;
      nextdata_n_q  <= nextdata_n_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_code_q    <= key_code_d;
      press_count_q <= press_count_d;
      ovf_q         <= ovf_d;
      shift_down_q  <= shift_down_d;
    end
  end

  scan2ascii u_scan2ascii (
    .code  (key_code_q),
    .shift (shift_down_q),
    .ascii (key_ascii)
  );

  // Key digits blank when nothing is held; counter digits always show.
  always_comb begin
    seg_out = '1;
    seg_out[6:0]   = key_held_q ? hex2seg(key_code_q[3:0]) : SEG_BLANK;
    seg_out[13:7]  = key_held_q ? hex2seg(key_code_q[7:4]) : SEG_BLANK;
    seg_out[20:14] = key_held_q ? hex2seg(key_ascii[3:0])  : SEG_BLANK;
    seg_out[27:21] = key_held_q ? hex2seg(key_ascii[7:4])  : SEG_BLANK;
    for (int i = 0; i < CNT_W / 4; i++) begin
      seg_out[7*(4+i) +: 7] = hex2seg(press_count_q[4*i +: 4]);
    end
  end

  assign nextdata_n    = nextdata_n_q;
  assign key_valid     = key_valid_q;
  assign key_held      = key_held_q;
  assign key_code      = key_code_q;
  assign press_count   = press_count_q;
  assign overflow_seen = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: default CNT_W=8 instance plus a CNT_W=4 instance fed the same stream.
module tb_ps2_key_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready = 1'b0;
  logic       in_overflow = 1'b0;

  logic       nextdata_n, key_valid, key_held, overflow_seen;
  logic [8:0] key_code;
  logic [7:0] key_ascii, press_count;
  logic [41:0] seg_out;

  logic       nextdata_n4, key_valid4, key_held4, overflow_seen4;
  logic [8:0] key_code4;
  logic [7:0] key_ascii4;
  logic [3:0] press_count4;
  logic [34:0] seg_out4;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int mark;

  always #5 clock = ~clock;

  always @(negedge clock) if (key_valid) pulses++;

  ps2_key_tracker dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_ready(in_ready),
    .in_overflow(in_overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
    .key_held(key_held), .key_code(key_code), .key_ascii(key_ascii),
    .press_count(press_count), .overflow_seen(overflow_seen), .seg_out(seg_out)
  );

  ps2_key_tracker #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_ready(in_ready),
    .in_overflow(in_overflow), .nextdata_n(nextdata_n4), .key_valid(key_valid4),
    .key_held(key_held4), .key_code(key_code4), .key_ascii(key_ascii4),
    .press_count(press_count4), .overflow_seen(overflow_seen4), .seg_out(seg_out4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    in_data  = b;
    in_ready = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (!nextdata_n) seen = 1'b1;
    end
    in_ready = 1'b0;
    if (!seen) check("pop_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lows;
    bit prev_low, dbl;
    bit seen;

    do_reset();
    check("rst_nextdata_n", nextdata_n, 1);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    check("rst_key_code", key_code, 9'h000);
    check("rst_count", press_count, 8'h00);
    check("rst_ovf", overflow_seen, 0);
    check("rst_dig0_blank", seg_out[6:0], 7'h7F);
    check("rst_dig4", seg_out[34:28], 7'h40);

    // Simple make / break.
    mark = pulses;
    send_byte(8'h1C);
    check("t1_held", key_held, 1);
    check("t1_code", key_code, 9'h01C);
    check("t1_ascii", key_ascii, 8'h61);
    check("t1_count", press_count, 8'h01);
    check("t1_dig0", seg_out[6:0], 7'h46);
    check("t1_dig1", seg_out[13:7], 7'h79);
    check("t1_dig2", seg_out[20:14], 7'h79);
    check("t1_dig3", seg_out[27:21], 7'h02);
    check("t1_dig4", seg_out[34:28], 7'h79);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t1_rel_held", key_held, 0);
    check("t1_rel_code", key_code, 9'h01C);
    check("t1_rel_dig0", seg_out[6:0], 7'h7F);
    check("t1_rel_dig1", seg_out[13:7], 7'h7F);
    check("t1_pulses", pulses - mark, 1);

    // Typematic repeats.
    mark = pulses;
    send_byte(8'h1B);
    send_byte(8'h1B);
    send_byte(8'h1B);
    check("t2_count_rep", press_count, 8'h02);
    check("t2_ascii", key_ascii, 8'h73);
    send_byte(8'hF0);
    send_byte(8'h1B);
    check("t2_pulses", pulses - mark, 1);
    check("t2_held", key_held, 0);

    // Extended key, both break orderings.
    send_byte(8'hE0); send_byte(8'h75);
    check("t3_code", key_code, 9'h175);
    check("t3_ascii", key_ascii, 8'h00);
    check("t3_held", key_held, 1);
    check("t3_count", press_count, 8'h03);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("t3_rel1", key_held, 0);
    send_byte(8'hE0); send_byte(8'h75);
    check("t3_held2", key_held, 1);
    send_byte(8'hF0); send_byte(8'h75);
    check("t3_nonext_brk_ignored", key_held, 1);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
    check("t3_rel2", key_held, 0);
    check("t3_count2", press_count, 8'h04);

    // Counter wrap with 16 alternating presses.
    do_reset();
    mark = pulses;
    for (int i = 0; i < 16; i++) begin
      send_byte((i % 2) ? 8'h1B : 8'h1C);
      if (i == 14) check("t4_cnt4_15", press_count4, 4'hF);
    end
    check("t4_cnt4_wrap", press_count4, 4'h0);
    check("t4_dut4_dig4", seg_out4[34:28], 7'h40);
    check("t4_cnt8", press_count, 8'h10);
    check("t4_dig4", seg_out[34:28], 7'h40);
    check("t4_dig5", seg_out[41:35], 7'h79);
    check("t4_last_wins", key_code, 9'h01B);
    check("t4_held", key_held, 1);
    check("t4_pulses", pulses - mark, 16);

    // Shift handling.
    do_reset();
    mark = pulses;
    send_byte(8'h12);
    send_byte(8'h1C);
`ifdef KBD_SHIFT_EN
    check("t5_upper", key_ascii, 8'h41);
    check("t5_count1", press_count, 8'h01);
`else
    check("t5_lower", key_ascii, 8'h61);
    check("t5_count1", press_count, 8'h02);
`endif
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h1C);
    check("t5_ascii_end", key_ascii, 8'h61);
    check("t5_code_end", key_code, 9'h01C);
`ifdef KBD_SHIFT_EN
    check("t5_count_end", press_count, 8'h02);
    check("t5_pulses", pulses - mark, 2);
`else
    check("t5_count_end", press_count, 8'h03);
    check("t5_pulses", pulses - mark, 3);
`endif

    // Sticky overflow flag.
    in_overflow = 1'b1;
    @(negedge clock);
    in_overflow = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_ovf_sticky", overflow_seen, 1);

    // Back-to-back pops with in_ready held high.
    in_data  = 8'hF0;
    in_ready = 1'b1;
    lows = 0;
    prev_low = 1'b0;
    dbl = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!nextdata_n) begin
        lows++;
        if (prev_low) dbl = 1'b1;
      end
      prev_low = !nextdata_n;
    end
    check("t7_pop_lows", lows, 10);
    check("t7_no_double_low", dbl, 0);

    // Reset landing while in POP.
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (!nextdata_n) seen = 1'b1;
      else @(negedge clock);
    end
    check("t7_found_pop", seen, 1);
    reset = 1'b1;
    @(negedge clock);
    check("t7_rst_nextdata_n", nextdata_n, 1);
    check("t7_rst_held", key_held, 0);
    check("t7_rst_code", key_code, 9'h000);
    check("t7_rst_count", press_count, 8'h00);
    check("t7_rst_ovf", overflow_seen, 0);
    check("t7_rst_valid", key_valid, 0);
    reset    = 1'b0;
    in_ready = 1'b0;
    @(negedge clock);
    send_byte(8'h1C);
    check("t7_brk_cleared_held", key_held, 1);
    check("t7_brk_cleared_count", press_count, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
